// File: rtl/bidir_switch_array.sv
// Clocked replacement for a tranif1 pass switch: CHANNELS registered links between side A and
// side B, each off/A->B/B->A, configured through a serial chain with a turnaround on reversal.
module bidir_switch_array #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_en,
  input  logic                      cfg_in,
  output logic                      cfg_out,
  input  logic                      cfg_commit,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  output logic [CHANNELS*WIDTH-1:0] a_out,
  output logic [CHANNELS-1:0]       a_oe,
  input  logic [CHANNELS*WIDTH-1:0] b_in,
  output logic [CHANNELS*WIDTH-1:0] b_out,
  output logic [CHANNELS-1:0]       b_oe,
  output logic [CHANNELS-1:0]       busy
);

  localparam int unsigned ChainLen = 2 * CHANNELS;
  localparam logic [3:0]  TurnCnt  = 4'(TURNAROUND);

  localparam logic [1:0] StOff  = 2'd0;
  localparam logic [1:0] StA2b  = 2'd1;
  localparam logic [1:0] StB2a  = 2'd2;
  localparam logic [1:0] StTurn = 2'd3;

  logic [ChainLen-1:0]           chain_q, chain_d;
  logic [ChainLen-1:0]           active_q, active_d;
  logic [CHANNELS-1:0][1:0]      state_q, state_d;
  logic [CHANNELS-1:0]           tgt_q, tgt_d;
  logic [CHANNELS-1:0][3:0]      cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0]     a_out_q, a_out_d;
  logic [CHANNELS*WIDTH-1:0]     b_out_q, b_out_d;

  always_comb begin
    logic en, dir, turn;
    chain_d  = cfg_en ? {chain_q[ChainLen-2:0], cfg_in} : chain_q;
    // Commit captures the chain as it stood before this cycle's shift.
    active_d = cfg_commit ? chain_q : active_q;
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    a_out_d  = a_out_q;
    b_out_d  = b_out_q;
    en       = 1'b0;
    dir      = 1'b0;
    turn     = 1'b0;

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      en   = active_q[2*k+1];
      dir  = active_q[2*k];
      turn = 1'b0;

      if (state_q[k] == StA2b) b_out_d[k*WIDTH +: WIDTH] = a_in[k*WIDTH +: WIDTH];
      if (state_q[k] == StB2a) a_out_d[k*WIDTH +: WIDTH] = b_in[k*WIDTH +: WIDTH];

      if (!en) begin
        state_d[k] = StOff;
      end else begin
        unique case (state_q[k])
          StOff:  turn = 1'b1;
          StA2b:  turn = dir;
          StB2a:  turn = ~dir;
          StTurn: begin
            if (dir != tgt_q[k]) begin
              turn = 1'b1;
            end else if (cnt_q[k] == 4'd1) begin
              state_d[k] = tgt_q[k] ? StB2a : StA2b;
            end else begin
              cnt_d[k] = cnt_q[k] - 4'd1;
            end
          end
          default: state_d[k] = StOff;
        endcase
      end

      if (turn) begin
        if (TURNAROUND == 0) begin
          state_d[k] = dir ? StB2a : StA2b;
        end else begin
          state_d[k] = StTurn;
          tgt_d[k]   = dir;
          cnt_d[k]   = TurnCnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q  <= '0;
      active_q <= '0;
      state_q  <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      a_out_q  <= '0;
      b_out_q  <= '0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      a_oe[k] = (state_q[k] == StB2a);
      b_oe[k] = (state_q[k] == StA2b);
      busy[k] = (state_q[k] == StTurn);
    end
  end

  assign cfg_out = chain_q[ChainLen-1];
  assign a_out   = a_out_q;
  assign b_out   = b_out_q;

endmodule

// File: tb/tb_bidir_switch_array.sv
// Bench for bidir_switch_array: timestamp-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bidir_switch_array;

  localparam int C  = 4;
  localparam int W  = 8;
  localparam int TA = 1;

  logic           clk = 1'b0;
  logic           rst, cfg_en, cfg_in, cfg_commit;
  logic [C*W-1:0] a_in, b_in;
  logic [C*W-1:0] a_out, b_out;
  logic [C-1:0]   a_oe, b_oe, busy;
  logic           cfg_out;

  int checks = 0;
  int errors = 0;

  bidir_switch_array #(.CHANNELS(C), .WIDTH(W), .TURNAROUND(TA)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .a_in       (a_in),
    .a_out      (a_out),
    .a_oe       (a_oe),
    .b_in       (b_in),
    .b_out      (b_out),
    .b_oe       (b_oe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: each channel holds an applied {en,dir} and the edge count at which
  // driving starts; everything before that while enabled is turnaround.
  int       mcyc = 0;
  bit       started = 1'b0;
  bit       mq[$];
  bit       act_en [C], act_dir [C], app_en [C], app_dir [C];
  int       start [C];
  logic [W-1:0] m_aout [C], m_bout [C];

  function automatic bit chain_bit(input int j);
    int idx = mq.size() - 1 - j;
    return (idx >= 0) ? mq[idx] : 1'b0;
  endfunction

  function automatic bit drives(input int k, input int now);
    return app_en[k] && (now >= start[k]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      for (int k = 0; k < C; k++) begin
        act_en[k] = 0; act_dir[k] = 0; app_en[k] = 0; app_dir[k] = 0;
        start[k] = 0; m_aout[k] = '0; m_bout[k] = '0;
      end
      mcyc++;
    end else begin
      for (int k = 0; k < C; k++) begin
        if (drives(k, mcyc) && !app_dir[k]) m_bout[k] = a_in[k*W +: W];
        if (drives(k, mcyc) &&  app_dir[k]) m_aout[k] = b_in[k*W +: W];
      end
      mcyc++;
      for (int k = 0; k < C; k++) begin
        if (act_en[k] != app_en[k] || (act_en[k] && act_dir[k] != app_dir[k])) begin
          if (act_en[k]) start[k] = mcyc + TA;
          app_en[k]  = act_en[k];
          app_dir[k] = act_dir[k];
        end
      end
      if (cfg_commit) begin
        for (int k = 0; k < C; k++) begin
          act_dir[k] = chain_bit(2*k);
          act_en[k]  = chain_bit(2*k+1);
        end
      end
      if (cfg_en) begin
        mq.push_back(cfg_in);
        if (mq.size() > 2*C) void'(mq.pop_front());
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [C*W-1:0] ea, eb;
      logic [C-1:0]   eaoe, eboe, ebusy;
      logic           ecfg;
      for (int k = 0; k < C; k++) begin
        ea[k*W +: W] = m_aout[k];
        eb[k*W +: W] = m_bout[k];
        eaoe[k]  = drives(k, mcyc) &&  app_dir[k];
        eboe[k]  = drives(k, mcyc) && !app_dir[k];
        ebusy[k] = app_en[k] && (mcyc < start[k]);
      end
      ecfg = (mq.size() >= 2*C) ? mq[mq.size()-2*C] : 1'b0;
      checks++;
      if ({a_out, b_out, a_oe, b_oe, busy, cfg_out} !== {ea, eb, eaoe, eboe, ebusy, ecfg}) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d: got a=%h b=%h aoe=%b boe=%b busy=%b cfg=%b, expected a=%h b=%h aoe=%b boe=%b busy=%b cfg=%b",
                 mcyc, a_out, b_out, a_oe, b_oe, busy, cfg_out,
                 ea, eb, eaoe, eboe, ebusy, ecfg);
      end
      checks++;
      if ((a_oe & b_oe) !== '0) begin
        errors++;
        $display("FAIL oe_exclusive cyc=%0d: got a_oe&b_oe=%b expected 0", mcyc, a_oe & b_oe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic shift_cfg(input logic [2*C-1:0] val);
    for (int i = 2*C-1; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_in = val[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 0; cfg_in = 0; cfg_commit = 0; a_in = '0; b_in = '0;
    tick(); tick();
    chk("reset_oe", {a_oe, b_oe}, '0);
    chk("reset_out", {a_out, b_out}, '0);
    chk("reset_busy_cfg", {busy, cfg_out}, '0);
    rst = 1'b0;

    // Enable ch0 A->B
    a_in[7:0] = 8'hA5;
    shift_cfg(8'b0000_0010);
    commit();
    chk("t2_commit_edge_busy", busy, 4'b0000);
    tick();
    chk("t2_turn_busy", busy, 4'b0001);
    chk("t2_turn_oe", {a_oe, b_oe}, 8'h00);
    tick();
    chk("t2_drive_oe", {a_oe, b_oe, busy}, 12'b0000_0001_0000);
    tick();
    chk("t2_b_out", b_out[7:0], 8'hA5);
    chk("t2_a_oe", a_oe, 4'b0000);

    // Reverse ch0
    b_in[7:0] = 8'h3C;
    shift_cfg(8'b0000_0011);
    commit();
    tick();
    chk("t3_turn", {a_oe, b_oe, busy}, 12'b0000_0000_0001);
    tick();
    chk("t3_a_oe", {a_oe, b_oe}, 8'b0001_0000);
    tick();
    chk("t3_a_out", a_out[7:0], 8'h3C);
    chk("t3_b_hold", b_out[7:0], 8'hA5);

    // Unchanged re-commit
    commit();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_busy", {busy, a_oe}, 8'b0000_0001);
    end

    // Disable ch0
    shift_cfg(8'b0000_0001);
    commit();
    tick();
    chk("t4_off", {a_oe, b_oe, busy}, '0);
    b_in[7:0] = 8'hFF;
    tick(); tick();
    chk("t4_hold", a_out[7:0], 8'h3C);

    // cfg_out daisy-chain
    shift_cfg(8'b1000_0000);
    chk("cfg_out_msb", cfg_out, 1'b1);

    // Reset mid-turnaround
    shift_cfg(8'b0010_0000);
    commit();
    tick();
    chk("mid_turn_busy", busy, 4'b0100);
    rst = 1'b1;
    tick();
    chk("mid_turn_reset", {a_out, b_out, a_oe, b_oe, busy, cfg_out}, '0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cfg_en     = $urandom_range(0, 1) == 1;
      cfg_in     = $urandom_range(0, 1) == 1;
      cfg_commit = $urandom_range(0, 7) == 0;
      a_in       = $urandom();
      b_in       = $urandom();
      tick();
    end
    cfg_en = 0; cfg_commit = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
